run_pulse_tx: RTL and testbench



---
 rtl/run_pulse_tx.sv | 164 ++++++++++++++++
 tb/tb_run_pulse_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/run_pulse_tx.sv
// run_pulse_tx: serial run-length transmitter.
// An accepted length N is sent as N consecutive '1' cycles on out_o, followed by
// GAP_CYCLES '0' cycles. One holding register lets the next train start right
// after the current gap, so no idle cycles appear between trains.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - asynchronous active-high reset
//   len_i    - run length, sampled when valid_i && ready_o
//   valid_i  - len_i valid
//   ready_o  - hold register empty; a value can be accepted this cycle
//   out_o    - registered serial pulse line
//   busy_o   - a train (run or gap) is in progress
//   done_o   - high during the final gap cycle of each train
module run_pulse_tx #(
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             out_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   run_cnt_q, run_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               out_q, out_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               load_en;
  logic [LEN_W-1:0]   load_len;

  // ready depends only on the hold flag, never on valid_i
  assign accept  = valid_i && !hold_full_q;
  assign ready_o = !hold_full_q;
  assign out_o   = out_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      run_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      out_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, counter and hold-register logic
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_en     = 1'b0;
    load_len    = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_en  = 1'b1;
          load_len = len_i;
        end
      end

      S_RUN: begin
        if (accept) begin
          hold_d      = len_i;
          hold_full_d = 1'b1;
        end
        // run_cnt_q counts the '1' cycles still to send, including the current one
        if (run_cnt_q == LEN_W'(1)) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_W'(GAP_CYCLES);
        end else begin
          run_cnt_d = run_cnt_q - LEN_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          // End of gap: start the held train, else pass a fresh value straight through
          if (hold_full_q) begin
            load_en     = 1'b1;
            load_len    = hold_q;
            hold_full_d = 1'b0;
            if (accept) begin
              hold_d      = len_i;
              hold_full_d = 1'b1;
            end
          end else if (accept) begin
            load_en  = 1'b1;
            load_len = len_i;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (accept) begin
            hold_d      = len_i;
            hold_full_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Starting a train: zero-length trains go straight to the gap
    if (load_en) begin
      if (load_len != '0) begin
        state_d   = S_RUN;
        run_cnt_d = load_len;
      end else begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_W'(GAP_CYCLES);
      end
    end
  end

  // Registered outputs follow the next state so they line up with it
  always_comb begin
    out_d  = 1'b0;
    done_d = 1'b0;
    busy_d = 1'b0;
    out_d  = (state_d == S_RUN);
    done_d = (state_d == S_GAP) && (gap_cnt_d == GAP_W'(1));
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_run_pulse_tx.sv
// Testbench for run_pulse_tx: directed vector table, reset corner cases and
// random traffic checked against a cycle-stream reference model.
module tb_run_pulse_tx;

  localparam int unsigned LEN_W      = 3;
  localparam int unsigned GAP_CYCLES = 2;

  logic             clk_i;
  logic             reset_i;
  logic [LEN_W-1:0] len_i;
  logic             valid_i;
  logic             ready_o;
  logic             out_o;
  logic             busy_o;
  logic             done_o;

  int checks;
  int errors;

  run_pulse_tx #(.LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .len_i   (len_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .out_o   (out_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic             out;
    logic             done;
    logic             busy;
    logic             ready;
  } vec_t;

  // One future line cycle in the reference model
  typedef struct {
    logic out;
    logic done;
    logic start;
  } cyc_t;

  vec_t vecs[$];
  cyc_t stream[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic v, input int l, input logic o,
                              input logic d, input logic b, input logic r);
    vec_t e;
    e.valid = v;
    e.len   = LEN_W'(l);
    e.out   = o;
    e.done  = d;
    e.busy  = b;
    e.ready = r;
    vecs.push_back(e);
  endfunction

  task automatic check_all(input string tag, input logic o, input logic d,
                           input logic b, input logic r);
    chk({tag, ".out"},   out_o,   o);
    chk({tag, ".done"},  done_o,  d);
    chk({tag, ".busy"},  busy_o,  b);
    chk({tag, ".ready"}, ready_o, r);
  endtask

  // Model: hold is full while some queued train has not yet started on the line
  function automatic logic model_ready();
    foreach (stream[i]) if (stream[i].start) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_push(input int len);
    cyc_t c;
    for (int j = 0; j < len; j++) begin
      c.out = 1'b1; c.done = 1'b0; c.start = (j == 0);
      stream.push_back(c);
    end
    for (int g = 0; g < int'(GAP_CYCLES); g++) begin
      c.out = 1'b0; c.done = (g == int'(GAP_CYCLES) - 1); c.start = (len == 0) && (g == 0);
      stream.push_back(c);
    end
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    len_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_i = 1'b1;
    valid_i = 1'b1;
    len_i   = LEN_W'(5);

    // Reset held with valid input: nothing accepted, outputs at reset values
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    valid_i = 1'b0;
    reset_i = 1'b0;

    // Directed table: {valid, len, out, done, busy, ready} after each edge
    // single train len=3
    add(1, 3, 1, 0, 1, 1);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    // len=0
    add(1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    // back-to-back 2 then 4; valid with len 5 held while not ready is ignored
    add(1, 2, 1, 0, 1, 1);
    add(1, 4, 1, 0, 1, 0);
    add(1, 5, 0, 0, 1, 0);
    add(1, 5, 0, 1, 1, 0);
    add(1, 5, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    // max length 7
    add(1, 7, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      valid_i = vecs[i].valid;
      len_i   = vecs[i].len;
      @(posedge clk_i);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].done, vecs[i].busy, vecs[i].ready);
    end
    valid_i = 1'b0;

    // Reset mid-run with the hold register full
    valid_i = 1'b1; len_i = LEN_W'(5);
    @(posedge clk_i); #1;
    check_all("mr_acc5", 1'b1, 1'b0, 1'b1, 1'b1);
    valid_i = 1'b1; len_i = LEN_W'(3);
    @(posedge clk_i); #1;
    check_all("mr_hold3", 1'b1, 1'b0, 1'b1, 1'b0);
    valid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check_all("mr_async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check_all("mr_after", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Random traffic against the stream model
    do_reset();
    stream.delete();
    for (int i = 0; i < 2000; i++) begin
      logic acc;
      logic eo, ed, eb;
      cyc_t c;
      valid_i = ($urandom_range(0, 2) != 0);
      len_i   = LEN_W'($urandom_range(0, 7));
      acc     = valid_i && model_ready();
      @(posedge clk_i);
      #1;
      if (acc) model_push(int'(len_i));
      if (stream.size() > 0) begin
        c  = stream.pop_front();
        eo = c.out; ed = c.done; eb = 1'b1;
      end else begin
        eo = 1'b0; ed = 1'b0; eb = 1'b0;
      end
      check_all("rnd", eo, ed, eb, model_ready());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
